// File: rtl/noc_pkg.sv
// Shared constants and types for the mesh router: direction codes,
// default geometry and the output-arbiter state encoding.
package noc_pkg;

    localparam int unsigned DIR_W   = 3;
    localparam int unsigned N_PORTS = 5;

    // West is DIR_WEST because DIR_W already names the code width.
    localparam logic [DIR_W-1:0] DIR_L    = 3'd0;
    localparam logic [DIR_W-1:0] DIR_N    = 3'd1;
    localparam logic [DIR_W-1:0] DIR_E    = 3'd2;
    localparam logic [DIR_W-1:0] DIR_S    = 3'd3;
    localparam logic [DIR_W-1:0] DIR_WEST = 3'd4;

    // An idle crossbar select is encoded as the port count itself.
    localparam int unsigned SEL_IDLE = N_PORTS;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first eligible index at or above ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int unsigned j;
        logic [W-1:0] jj;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = W'(j);
            if (!found && eligible[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/rr_output_arbiter.sv
// Per-output round-robin arbiter with optional wormhole locking; drives
// the crossbar select and grant/dequeue strobes back to the input buffers.
module rr_output_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned N_PORTS  = 5,
    parameter int unsigned DIR_W    = 3,
    parameter int unsigned SEL_W    = 3,
    parameter bit          WORMHOLE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIR_W-1:0]         my_dir,
    input  logic [N_PORTS-1:0]       req_valid,
    input  logic [N_PORTS*DIR_W-1:0] req_dir,
    input  logic [N_PORTS-1:0]       req_tail,
    input  logic                     out_ready,
    output logic [N_PORTS-1:0]       grant,
    output logic [SEL_W-1:0]         select,
    output logic [N_PORTS-1:0]       xfer,
    output logic                     busy
);

    localparam logic [SEL_W-1:0]   SEL_NONE = SEL_W'(N_PORTS);
    localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(N_PORTS - 1);
    localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);

    arb_state_e         state, next_state;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   select_q, select_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [N_PORTS-1:0] eligible;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic               release_now;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            eligible[i] = req_valid[i] && (req_dir[i*DIR_W +: DIR_W] == my_dir);
        end
    end

    rr_pick #(
        .N (N_PORTS),
        .W (SEL_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    assign xfer = grant_q & req_valid & {N_PORTS{out_ready}};

    // Wormhole waits for the tail flit to move; otherwise any moved flit releases.
    always_comb begin
        if (WORMHOLE) begin
            release_now = |(xfer & req_tail);
        end else begin
            release_now = |xfer;
        end
    end

    always_comb begin
        next_state = state;
        grant_d    = grant_q;
        select_d   = select_q;
        ptr_d      = ptr_q;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = ONE_HOT0 << pick_idx;
                    select_d   = pick_idx;
                    next_state = LOCKED;
                end
            end
            LOCKED: begin
                if (release_now) begin
                    grant_d    = '0;
                    select_d   = SEL_NONE;
                    ptr_d      = (select_q == SEL_LAST) ? '0 : select_q + 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                grant_d    = '0;
                select_d   = SEL_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            select_q <= SEL_NONE;
            ptr_q    <= '0;
        end else begin
            state    <= next_state;
            grant_q  <= grant_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant  = grant_q;
    assign select = select_q;
    assign busy   = (state == LOCKED);

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter: one wormhole and one per-flit instance
// share the same request inputs.
module tb_rr_output_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  my_dir;
    logic [4:0]  req_valid;
    logic [14:0] req_dir;
    logic [4:0]  req_tail;
    logic        out_ready;

    logic [4:0]  grant, xfer;
    logic [2:0]  select;
    logic        busy;
    logic [4:0]  grant_nw, xfer_nw;
    logic [2:0]  select_nw;
    logic        busy_nw;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_output_arbiter #(
        .N_PORTS  (5),
        .DIR_W    (3),
        .SEL_W    (3),
        .WORMHOLE (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .my_dir    (my_dir),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_tail  (req_tail),
        .out_ready (out_ready),
        .grant     (grant),
        .select    (select),
        .xfer      (xfer),
        .busy      (busy)
    );

    rr_output_arbiter #(
        .N_PORTS  (5),
        .DIR_W    (3),
        .SEL_W    (3),
        .WORMHOLE (1'b0)
    ) dut_nw (
        .clk       (clk),
        .rst       (rst),
        .my_dir    (my_dir),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_tail  (req_tail),
        .out_ready (out_ready),
        .grant     (grant_nw),
        .select    (select_nw),
        .xfer      (xfer_nw),
        .busy      (busy_nw)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dir(input int i, input logic [2:0] d);
        req_dir[i*3 +: 3] = d;
    endtask

    task automatic quiet_inputs();
        req_valid = '0;
        req_tail  = '0;
        req_dir   = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rem1, rem2, cnt1, cnt2;
        logic [4:0] nw_exp [12];
        logic [2:0] rot_exp [7];

        my_dir = 3'd2;
        quiet_inputs();
        rst = 1'b1;
        #2;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_select", 32'(select), 32'd5);
        chk("reset_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;

        // Reset in the middle of a packet from input 2.
        req_valid = 5'b00100;
        set_dir(2, 3'd2);
        req_tail = 5'b00000;
        tick();
        chk("lock2_grant", 32'(grant), 32'h04);
        chk("lock2_select", 32'(select), 32'd2);
        chk("lock2_busy", 32'(busy), 32'd1);
        tick();
        chk("lock2_body_xfer", 32'(xfer), 32'h04);
        rst = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_select", 32'(select), 32'd5);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_xfer", 32'(xfer), 32'h0);
        rst = 1'b0;
        req_valid = 5'b11111;
        req_dir   = {5{3'd2}};
        req_tail  = 5'b11111;
        tick();
        chk("post_rst_grant", 32'(grant), 32'h01);
        chk("post_rst_select", 32'(select), 32'd0);

        // Rotation over inputs 0, 1, 3 with single-flit packets.
        rot_exp = '{3'd0, 3'd5, 3'd1, 3'd5, 3'd3, 3'd5, 3'd0};
        do_reset();
        req_valid = 5'b01011;
        req_dir   = {5{3'd2}};
        req_tail  = 5'b11111;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("rot_select_%0d", k), 32'(select), 32'(rot_exp[k]));
        end

        // Only input 4 targets this output.
        do_reset();
        req_valid = 5'b11111;
        req_dir   = {3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
        req_tail  = 5'b00000;
        tick();
        chk("dir_grant", 32'(grant), 32'h10);
        chk("dir_select", 32'(select), 32'd4);
        chk("dir_xfer", 32'(xfer), 32'h10);

        // Four-flit packet from input 1 with a three-cycle stall; input 2 waits.
        do_reset();
        req_valid = 5'b00110;
        req_dir   = {5{3'd2}};
        req_tail  = 5'b00000;
        tick();
        chk("wh_head_grant", 32'(grant), 32'h02);
        chk("wh_head_xfer", 32'(xfer), 32'h02);
        tick();
        chk("wh_body1_xfer", 32'(xfer), 32'h02);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("wh_stall_grant_%0d", k), 32'(grant), 32'h02);
            chk($sformatf("wh_stall_xfer_%0d", k), 32'(xfer), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("wh_body2_xfer", 32'(xfer), 32'h02);
        tick();
        req_tail = 5'b00010;
        #1;
        chk("wh_tail_grant", 32'(grant), 32'h02);
        chk("wh_tail_xfer", 32'(xfer), 32'h02);
        tick();
        req_valid = 5'b00100;
        req_tail  = 5'b00000;
        chk("wh_bubble_select", 32'(select), 32'd5);
        chk("wh_bubble_busy", 32'(busy), 32'd0);
        tick();
        chk("wh_next_select", 32'(select), 32'd2);
        chk("wh_next_grant", 32'(grant), 32'h04);

        // Wrap-around: release of input 3 moves the pointer to 4.
        do_reset();
        req_valid = 5'b01000;
        req_dir   = {5{3'd2}};
        req_tail  = 5'b11111;
        tick();
        chk("wrap_sel3", 32'(select), 32'd3);
        req_valid = 5'b11001;
        tick();
        chk("wrap_idle1", 32'(select), 32'd5);
        req_valid = 5'b10001;
        tick();
        chk("wrap_sel4", 32'(select), 32'd4);
        chk("wrap_grant4", 32'(grant), 32'h10);
        tick();
        chk("wrap_idle2", 32'(select), 32'd5);
        tick();
        chk("wrap_sel0", 32'(select), 32'd0);

        // Per-flit mode: inputs 1 and 2 each stream three flits.
        nw_exp = '{5'b00010, 5'b0, 5'b00100, 5'b0, 5'b00010, 5'b0,
                   5'b00100, 5'b0, 5'b00010, 5'b0, 5'b00100, 5'b0};
        do_reset();
        req_dir = {5{3'd2}};
        rem1 = 3;
        rem2 = 3;
        cnt1 = 0;
        cnt2 = 0;
        req_valid = 5'b00110;
        req_tail  = 5'b00000;
        for (int k = 0; k < 12; k++) begin
            tick();
            req_valid[1] = (rem1 > 0);
            req_valid[2] = (rem2 > 0);
            req_tail[1]  = (rem1 == 1);
            req_tail[2]  = (rem2 == 1);
            #1;
            chk($sformatf("nw_grant_%0d", k), 32'(grant_nw), 32'(nw_exp[k]));
            if (xfer_nw[1]) begin
                cnt1++;
                rem1--;
            end
            if (xfer_nw[2]) begin
                cnt2++;
                rem2--;
            end
        end
        chk("nw_count_in1", 32'(cnt1), 32'd3);
        chk("nw_count_in2", 32'(cnt2), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
